n64_drive_mixer: RTL and testbench
==================================

# n64_drive_mixer

Downstream consumer of the N64 controller reader. Takes each 32-bit button/stick word the reader captures, decodes stick X/Y and buttons, mixes them into differential left/right motor commands, and drives two sign-magnitude PWM channels for the robot's H-bridges. Includes arming control and a link-loss watchdog, so the motors stop when frames stop arriving.

## Interface
- PWM_DIV, 392: PCLK cycles per PWM counter tick (≈1 kHz PWM at 100 MHz)
- DEADZONE, 8: stick magnitudes below this are treated as 0
- TIMEOUT_CYCLES, 5_000_000: cycles without frame_valid before failsafe
- PCLK  in  1  clock
- PRESERN  in  1  reset; asynchronous, active-low
- frame_data  in  32  raw word in capture order: bit0 is the first bit received
- frame_valid  in  1  one-cycle strobe; frame_data is valid while it is high
- left_pwm, right_pwm  out  1  PWM magnitude outputs
- left_dir, right_dir  out  1  1 = reverse, 0 = forward
- armed  out  1  high in ARMED
- failsafe  out  1  high in FAILSAFE
- stick_x, stick_y  out  8  decoded signed stick values, for debug/APB readback

## Operation
- **Word layout:**
  - bit0 A, bit1 B, bit2 Z, bit3 Start, bits4-7 D-pad U/D/L/R, bits10/11 L/R, bits12-15 C U/D/L/R.
  - bits16-23 hold X, MSB at bit16. bits24-31 hold Y, MSB at bit24.
  - Both stick bytes are bit-reversed on decode, giving two's-complement X/Y.
- **Deadzone:** if |v| < DEADZONE then v = 0. Applied per axis, before mixing.
- **Mix:** 9-bit signed arithmetic.
  - left = Y + X, right = Y − X.
  - Each result saturates to [−127, +127]. −128 input is treated as −127.
- **Outputs:** dir = sign of the result. duty = 2·|cmd|, range 0..254.
- **State machine:** DISARMED, ARMED, FAILSAFE. Reset state is DISARMED.
  - DISARMED → ARMED on a Start rising edge, i.e. Start=1 in this frame and Start=0 in the previous frame.
  - ARMED → DISARMED on a Start rising edge.
  - ARMED → DISARMED when Z=1 in any frame. Z beats Start in the same frame.
  - Any state → FAILSAFE when the watchdog reaches TIMEOUT_CYCLES.
  - FAILSAFE → DISARMED on the next frame_valid. The previous-Start register is loaded from that frame, so a held Start does not re-arm.
- **Commands:** outside ARMED, both commands are forced to 0.
- **Watchdog:** counter clears on frame_valid, otherwise increments and saturates at TIMEOUT_CYCLES.
- **PWM channel:**
  - Prescaler counts 0..PWM_DIV−1. Period counter counts 0..254, advancing once per prescaler wrap.
  - Output is high while period counter < duty.
  - New duty and dir are loaded only when the period counter is 0 and the prescaler is 0, so there are no runt pulses.
  - Exception: a zero command entering FAILSAFE or DISARMED forces pwm low and dir 0 on the next cycle, not at the boundary.

## Timing
- **Reset values:** all outputs 0; state DISARMED; watchdog 0; PWM counters 0; prev-Start 0.
- **Latency:**
  - frame_valid at cycle N: stick_x/stick_y and the state update are registered at N+1.
  - Saturated commands are registered at N+2.
  - PWM picks up the new commands at the next period boundary, at most 255·PWM_DIV cycles later.
- **frame_valid on consecutive cycles:** each strobe is processed; the last one wins.
- **Watchdog tie:** frame_valid in the same cycle the watchdog would expire → the frame wins; no FAILSAFE.
- **Reset mid-period:** PRESERN low drops pwm/dir immediately (asynchronously). After release, the first period starts at counter 0.
- **Duty extremes:** duty 0 gives a constant-low output. duty 254 gives 254 high ticks out of 255.

## Structure
- **Shared package n64_pkg:**
  - Button bit-index constants and stick field positions.
  - Bit-reverse function.
  - State enum {DISARMED, ARMED, FAILSAFE}.
  - PWM period constant 255.
- **Sub-module n64_pwm_channel:** prescaler, period counter, boundary-latched duty/dir, force-off input. Instantiated twice.
- **Top level:** decode, deadzone, mix/saturate, FSM, watchdog.

## Test plan
- **Arming:** reset, then frames with Start=1, Start=0, Start=1 → armed goes 1, stays 1, then returns to 0. Held Start across 3 frames toggles once.
- **Forward mix:** armed; Y=+100, X=0 (bits24-31 = bit-reverse of 0x64) → left=right=+100, dir=0, duty 200. Measure 200 high ticks per 255.
- **Spin and saturation:** armed; Y=+100, X=+60 → left saturates to +127 (duty 254). right=+40: dir 0, duty 80.
- **Deadzone and brake:** X=+5, Y=−7 → both duties 0. Z=1 with full stick → state DISARMED and pwm low within 2 cycles.
- **Watchdog:** armed; stop frame_valid → failsafe=1 exactly TIMEOUT_CYCLES after the last strobe, with pwm low. Next frame → DISARMED, failsafe=0.
- **Async reset mid-PWM:** assert PRESERN=0 while pwm is high → pwm=0 with no clock edge. After release, outputs stay 0 until re-armed.

Source files
------------

// File: rtl/n64_pkg.sv
// Shared definitions for the N64 drive mixer: controller word layout,
// drive state encoding, PWM period and the stick-byte bit reversal.
package n64_pkg;

    localparam int unsigned BTN_A       = 0;
    localparam int unsigned BTN_B       = 1;
    localparam int unsigned BTN_Z       = 2;
    localparam int unsigned BTN_START   = 3;
    localparam int unsigned BTN_DU      = 4;
    localparam int unsigned BTN_DD      = 5;
    localparam int unsigned BTN_DL      = 6;
    localparam int unsigned BTN_DR      = 7;
    localparam int unsigned BTN_L       = 10;
    localparam int unsigned BTN_R       = 11;
    localparam int unsigned BTN_CU      = 12;
    localparam int unsigned BTN_CD      = 13;
    localparam int unsigned BTN_CL      = 14;
    localparam int unsigned BTN_CR      = 15;
    localparam int unsigned STICK_X_LSB = 16;
    localparam int unsigned STICK_Y_LSB = 24;
    localparam int unsigned STICK_W     = 8;

    localparam int unsigned PWM_PERIOD  = 255;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        FAILSAFE = 2'd2
    } drive_state_e;

    // Stick bytes arrive MSB-first, so the captured byte is bit-reversed.
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/n64_drive_mixer_if.sv
// Captured-frame bus from the N64 controller reader to the drive mixer.
interface n64_drive_mixer_if;
    logic [31:0] frame_data;
    logic        frame_valid;

    modport master (output frame_data, output frame_valid);
    modport slave  (input  frame_data, input  frame_valid);
endinterface

// File: rtl/n64_pwm_channel.sv
// One sign-magnitude PWM channel: duty/dir latched only at the period
// boundary, with an immediate force-off path for disarm/failsafe.
module n64_pwm_channel
    import n64_pkg::*;
#(
    parameter int unsigned PWM_DIV = 392
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] duty,
    input  logic       dir_cmd,
    input  logic       force_off,
    output logic       pwm,
    output logic       dir
);
    localparam int unsigned PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam int unsigned CNT_W = 8;

    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       duty_q;
    logic             pre_wrap;
    logic             boundary;
    logic [7:0]       duty_eff;

    assign pre_wrap = (pre == PRE_W'(PWM_DIV - 1));
    assign boundary = (pre == '0) && (cnt == '0);
    assign duty_eff = boundary ? duty : duty_q;

    // Prescaler and period counter run free; they never stop for force-off.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre <= '0;
            cnt <= '0;
        end else begin
            pre <= pre_wrap ? '0 : pre + PRE_W'(1);
            if (pre_wrap) begin
                cnt <= (cnt == CNT_W'(PWM_PERIOD - 1)) ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty_q <= '0;
            dir    <= 1'b0;
            pwm    <= 1'b0;
        end else if (force_off) begin
            duty_q <= '0;
            dir    <= 1'b0;
            pwm    <= 1'b0;
        end else begin
            if (boundary) begin
                duty_q <= duty;
                dir    <= dir_cmd;
            end
            pwm <= (cnt < duty_eff);
        end
    end

endmodule

// File: rtl/n64_drive_mixer.sv
// N64 controller word -> deadzone -> differential mix -> two PWM channels,
// gated by an arm/disarm FSM and a link-loss watchdog.
module n64_drive_mixer
    import n64_pkg::*;
#(
    parameter int unsigned PWM_DIV        = 392,
    parameter int unsigned DEADZONE       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
    input  logic               PCLK,
    input  logic               PRESERN,
    n64_drive_mixer_if.slave   bus,
    output logic               left_pwm,
    output logic               right_pwm,
    output logic               left_dir,
    output logic               right_dir,
    output logic               armed,
    output logic               failsafe,
    output logic signed [7:0]  stick_x,
    output logic signed [7:0]  stick_y
);
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_DISARMED = DISARMED;
    localparam logic [1:0] ST_ARMED    = ARMED;
    localparam logic [1:0] ST_FAILSAFE = FAILSAFE;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic              prev_start;
    logic [WD_W-1:0]   wd;
    logic              frame_start;
    logic              frame_z;
    logic              start_rise;
    logic              wd_expire;
    logic signed [7:0] x_sh;
    logic signed [7:0] y_sh;
    logic signed [8:0] left_sum;
    logic signed [8:0] right_sum;
    logic signed [7:0] cmd_left;
    logic signed [7:0] cmd_right;
    logic              force_off;

    function automatic logic signed [7:0] shape_axis(input logic signed [7:0] v);
        logic [8:0] mag;
        mag = v[7] ? 9'(-{v[7], v}) : {1'b0, v};
        if (mag < 9'(DEADZONE)) begin
            return '0;
        end else if (v == 8'sh80) begin
            return 8'sh81;
        end
        return v;
    endfunction

    function automatic logic signed [7:0] sat_cmd(input logic signed [8:0] s);
        if (s > 9'sd127) begin
            return 8'sd127;
        end else if (s < -9'sd127) begin
            return 8'sh81;
        end
        return s[7:0];
    endfunction

    function automatic logic [7:0] cmd_duty(input logic signed [7:0] c);
        logic [7:0] mag;
        mag = c[7] ? 8'(-c) : 8'(c);
        return mag << 1;
    endfunction

    assign frame_start = bus.frame_data[BTN_START];
    assign frame_z     = bus.frame_data[BTN_Z];
    assign start_rise  = frame_start && !prev_start;
    // A frame in the expiry cycle clears the watchdog, so the frame wins the tie.
    assign wd_expire   = !bus.frame_valid && (wd == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            state <= ST_DISARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (bus.frame_valid) begin
            case (state)
                ST_DISARMED: if (start_rise)            state_next = ST_ARMED;
                ST_ARMED:    if (frame_z || start_rise) state_next = ST_DISARMED;
                default:                                state_next = ST_DISARMED;
            endcase
        end else if (wd_expire) begin
            state_next = ST_FAILSAFE;
        end
    end

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            armed      <= 1'b0;
            failsafe   <= 1'b0;
            prev_start <= 1'b0;
            wd         <= '0;
            stick_x    <= '0;
            stick_y    <= '0;
        end else begin
            armed    <= (state_next == ST_ARMED);
            failsafe <= (state_next == ST_FAILSAFE);
            if (bus.frame_valid) begin
                prev_start <= frame_start;
                wd         <= '0;
                stick_x    <= bit_rev8(bus.frame_data[STICK_X_LSB +: STICK_W]);
                stick_y    <= bit_rev8(bus.frame_data[STICK_Y_LSB +: STICK_W]);
            end else if (wd != WD_W'(TIMEOUT_CYCLES)) begin
                wd <= wd + WD_W'(1);
            end
        end
    end

    assign x_sh      = shape_axis(stick_x);
    assign y_sh      = shape_axis(stick_y);
    assign left_sum  = $signed({y_sh[7], y_sh}) + $signed({x_sh[7], x_sh});
    assign right_sum = $signed({y_sh[7], y_sh}) - $signed({x_sh[7], x_sh});

    always_ff @(posedge PCLK or negedge PRESERN) begin
        if (!PRESERN) begin
            cmd_left  <= '0;
            cmd_right <= '0;
        end else if (state == ST_ARMED) begin
            cmd_left  <= sat_cmd(left_sum);
            cmd_right <= sat_cmd(right_sum);
        end else begin
            cmd_left  <= '0;
            cmd_right <= '0;
        end
    end

    // Leaving ARMED kills both outputs on the same edge the state changes.
    assign force_off = (state_next != ST_ARMED);

    n64_pwm_channel #(.PWM_DIV(PWM_DIV)) u_left (
        .clk       (PCLK),
        .rst_n     (PRESERN),
        .duty      (cmd_duty(cmd_left)),
        .dir_cmd   (cmd_left[7]),
        .force_off (force_off),
        .pwm       (left_pwm),
        .dir       (left_dir)
    );

    n64_pwm_channel #(.PWM_DIV(PWM_DIV)) u_right (
        .clk       (PCLK),
        .rst_n     (PRESERN),
        .duty      (cmd_duty(cmd_right)),
        .dir_cmd   (cmd_right[7]),
        .force_off (force_off),
        .pwm       (right_pwm),
        .dir       (right_dir)
    );

endmodule

// File: tb/tb_n64_drive_mixer.sv
// Randomised self-checking bench for n64_drive_mixer against a behavioural
// model of arming, deadzone/mix/saturation and PWM duty.
module tb_n64_drive_mixer;
    localparam int unsigned PWM_DIV  = 2;
    localparam int unsigned DEADZONE = 8;
    localparam int unsigned TIMEOUT  = 2000;
    localparam int          PER      = 255 * int'(PWM_DIV);
    localparam int          MS_DIS   = 0;
    localparam int          MS_ARM   = 1;
    localparam int          MS_FS    = 2;

    logic clk;
    logic rst_n;
    logic left_pwm, right_pwm, left_dir, right_dir, armed, failsafe;
    logic signed [7:0] stick_x, stick_y;

    n64_drive_mixer_if bus();

    n64_drive_mixer #(
        .PWM_DIV        (PWM_DIV),
        .DEADZONE       (DEADZONE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .PCLK      (clk),
        .PRESERN   (rst_n),
        .bus       (bus),
        .left_pwm  (left_pwm),
        .right_pwm (right_pwm),
        .left_dir  (left_dir),
        .right_dir (right_dir),
        .armed     (armed),
        .failsafe  (failsafe),
        .stick_x   (stick_x),
        .stick_y   (stick_y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_state = MS_DIS;
    bit m_prev  = 1'b0;

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int ref_axis(input int v);
        int t;
        t = (v == -128) ? -127 : v;
        if (iabs(t) < int'(DEADZONE)) return 0;
        return t;
    endfunction

    function automatic int ref_clamp(input int v);
        if (v > 127)  return 127;
        if (v < -127) return -127;
        return v;
    endfunction

    function automatic logic [31:0] build_word(input logic [7:0] x, input logic [7:0] y,
                                               input bit start, input bit z);
        logic [31:0] w;
        w    = 32'($urandom());
        w[2] = z;
        w[3] = start;
        for (int i = 0; i < 8; i++) begin
            w[16+i] = x[7-i];
            w[24+i] = y[7-i];
        end
        return w;
    endfunction

    task automatic model_frame(input bit start, input bit z);
        bit rise;
        rise = start && !m_prev;
        if (m_state == MS_FS)       m_state = MS_DIS;
        else if (m_state == MS_ARM) begin
            if (z || rise) m_state = MS_DIS;
        end else if (rise)          m_state = MS_ARM;
        m_prev = start;
    endtask

    task automatic send_frame(input logic [7:0] x, input logic [7:0] y, input bit start, input bit z);
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.frame_data  = build_word(x, y, start, z);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        bus.frame_data  = 32'($urandom());
        model_frame(start, z);
    endtask

    task automatic arm();
        send_frame(8'h00, 8'h00, 1'b0, 1'b0);
        send_frame(8'h00, 8'h00, 1'b1, 1'b0);
        send_frame(8'h00, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic measure(input string name, input logic [7:0] x, input logic [7:0] y);
        int rx, ry, cl, cr, hl, hr, el, er;
        rx = ref_axis(int'($signed(x)));
        ry = ref_axis(int'($signed(y)));
        cl = (m_state == MS_ARM) ? ref_clamp(ry + rx) : 0;
        cr = (m_state == MS_ARM) ? ref_clamp(ry - rx) : 0;
        el = 2 * iabs(cl) * int'(PWM_DIV);
        er = 2 * iabs(cr) * int'(PWM_DIV);
        repeat (PER + 10) @(negedge clk);
        hl = 0;
        hr = 0;
        repeat (PER) begin
            @(negedge clk);
            if (left_pwm)  hl++;
            if (right_pwm) hr++;
        end
        checks++;
        if (hl != el) begin
            errors++;
            $display("FAIL %s left_high got=%0d exp=%0d (x=%0d y=%0d)", name, hl, el, rx, ry);
        end
        checks++;
        if (hr != er) begin
            errors++;
            $display("FAIL %s right_high got=%0d exp=%0d (x=%0d y=%0d)", name, hr, er, rx, ry);
        end
        checks++;
        if (left_dir !== 1'(cl < 0)) begin
            errors++;
            $display("FAIL %s left_dir got=%b exp=%b", name, left_dir, cl < 0);
        end
        checks++;
        if (right_dir !== 1'(cr < 0)) begin
            errors++;
            $display("FAIL %s right_dir got=%b exp=%b", name, right_dir, cr < 0);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({armed, failsafe, left_pwm, right_pwm, left_dir, right_dir} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {armed, failsafe, left_pwm, right_pwm, left_dir, right_dir});
        end
        checks++;
        if ({stick_x, stick_y} !== 16'h0) begin
            errors++;
            $display("FAIL reset_sticks got=%h exp=0000", {stick_x, stick_y});
        end
    endtask

    task automatic test_arming();
        bit seq_start[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 7; i++) begin
            send_frame(8'h00, 8'h00, seq_start[i], 1'b0);
            checks++;
            if (armed !== 1'(m_state == MS_ARM)) begin
                errors++;
                $display("FAIL arming_step%0d got=%b exp=%b", i, armed, m_state == MS_ARM);
            end
        end
        send_frame(8'h00, 8'h00, 1'b0, 1'b1);
        checks++;
        if (armed !== 1'b0) begin
            errors++;
            $display("FAIL arming_z_disarm got=%b exp=0", armed);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.frame_valid = 1'b1;
        bus.frame_data  = build_word(8'h11, 8'h05, 1'b0, 1'b0);
        model_frame(1'b0, 1'b0);
        @(negedge clk);
        bus.frame_data  = build_word(8'h22, 8'h33, 1'b1, 1'b0);
        model_frame(1'b1, 1'b0);
        @(negedge clk);
        bus.frame_valid = 1'b0;
        checks++;
        if ({stick_x, stick_y} !== 16'h2233) begin
            errors++;
            $display("FAIL b2b_last_wins got=%h exp=2233", {stick_x, stick_y});
        end
        checks++;
        if (armed !== 1'(m_state == MS_ARM)) begin
            errors++;
            $display("FAIL b2b_armed got=%b exp=%b", armed, m_state == MS_ARM);
        end
    endtask

    task automatic test_mix_directed();
        send_frame(8'h00, 8'd100, 1'b0, 1'b0);
        measure("forward", 8'h00, 8'd100);
        send_frame(8'd60, 8'd100, 1'b0, 1'b0);
        measure("spin_sat", 8'd60, 8'd100);
        send_frame(8'd5, 8'hF9, 1'b0, 1'b0);
        measure("deadzone", 8'd5, 8'hF9);
    endtask

    task automatic test_brake();
        send_frame(8'h00, 8'd127, 1'b0, 1'b0);
        repeat (PER + 10) @(negedge clk);
        send_frame(8'd127, 8'd127, 1'b0, 1'b1);
        checks++;
        if ({armed, left_pwm, right_pwm, left_dir, right_dir} !== 5'b0) begin
            errors++;
            $display("FAIL brake got=%b exp=00000", {armed, left_pwm, right_pwm, left_dir, right_dir});
        end
    endtask

    task automatic test_random_mix();
        logic [7:0] x, y;
        arm();
        for (int it = 0; it < 5; it++) begin
            x = (it == 0) ? 8'h80 : 8'($urandom_range(0, 255));
            y = (it == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            send_frame(x, y, 1'b0, 1'b0);
            checks++;
            if ({stick_x, stick_y} !== {x, y}) begin
                errors++;
                $display("FAIL rand_decode%0d got=%h exp=%h", it, {stick_x, stick_y}, {x, y});
            end
            measure("random", x, y);
        end
    endtask

    task automatic test_watchdog();
        int  k;
        bit  hit;
        send_frame(8'h00, 8'd127, 1'b0, 1'b0);
        repeat (TIMEOUT - 1) @(posedge clk);
        send_frame(8'h00, 8'd127, 1'b0, 1'b0);
        checks++;
        if ({failsafe, armed} !== 2'b01) begin
            errors++;
            $display("FAIL wd_tie got=%b exp=01", {failsafe, armed});
        end
        k   = 0;
        hit = 1'b0;
        while (!hit && k < int'(TIMEOUT) + 20) begin
            @(posedge clk);
            k++;
            #1;
            if (failsafe) hit = 1'b1;
        end
        m_state = MS_FS;
        checks++;
        if (k != int'(TIMEOUT)) begin
            errors++;
            $display("FAIL wd_expiry_cycle got=%0d exp=%0d", k, TIMEOUT);
        end
        checks++;
        if ({armed, left_pwm, right_pwm} !== 3'b0) begin
            errors++;
            $display("FAIL wd_outputs_off got=%b exp=000", {armed, left_pwm, right_pwm});
        end
        send_frame(8'h00, 8'd127, 1'b1, 1'b0);
        checks++;
        if ({failsafe, armed} !== {1'(m_state == MS_FS), 1'(m_state == MS_ARM)}) begin
            errors++;
            $display("FAIL wd_recover got=%b exp=00", {failsafe, armed});
        end
        send_frame(8'h00, 8'd127, 1'b1, 1'b0);
        checks++;
        if (armed !== 1'(m_state == MS_ARM)) begin
            errors++;
            $display("FAIL wd_held_start got=%b exp=%b", armed, m_state == MS_ARM);
        end
    endtask

    task automatic test_async_reset();
        int hi;
        int n;
        arm();
        send_frame(8'h00, 8'd127, 1'b0, 1'b0);
        n = 0;
        while (!left_pwm && n < 2 * PER + 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (left_pwm !== 1'b1) begin
            errors++;
            $display("FAIL areset_pwm_high_pre got=%b exp=1", left_pwm);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({armed, left_pwm, right_pwm, left_dir, right_dir} !== 5'b0) begin
            errors++;
            $display("FAIL areset_immediate got=%b exp=00000",
                     {armed, left_pwm, right_pwm, left_dir, right_dir});
        end
        repeat (3) @(negedge clk);
        rst_n   = 1'b1;
        m_state = MS_DIS;
        m_prev  = 1'b0;
        hi      = 0;
        repeat (PER + 20) begin
            @(negedge clk);
            if (left_pwm || right_pwm) hi++;
        end
        checks++;
        if (hi != 0 || armed !== 1'b0) begin
            errors++;
            $display("FAIL areset_stays_off got_high=%0d armed=%b exp_high=0 armed=0", hi, armed);
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.frame_valid = 1'b0;
        bus.frame_data  = '0;
        repeat (3) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_arming();
        test_back_to_back();
        test_mix_directed();
        test_brake();
        test_random_mix();
        test_watchdog();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
